// File: rtl/nn_act_unit.sv
// rtl/nn_act_unit.sv - CH-lane two-stage saturating-linear activation / derivative unit
// Optional feature macro: NN_ACT_SATCNT_EN (adds sat_count / sat_clr saturation-event counter)
module nn_act_unit #(
  parameter int CH        = 6,
  parameter int XW        = 17,
  parameter int YW        = 9,
  parameter int SLOPE_SH  = 1,
  parameter int FMAX      = 127,
  parameter int DERIV_VAL = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [CH*XW-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*YW-1:0] out_y,
  output logic             out_mode,
  output logic [CH-1:0]    sat_mask
`ifdef NN_ACT_SATCNT_EN
  ,
  input  logic             sat_clr,
  output logic [31:0]      sat_count
`endif
);

  // Saturation threshold at full input width; results at output width.
  localparam logic signed [XW-1:0] LIM_POS = XW'(FMAX << SLOPE_SH);
  localparam logic signed [XW-1:0] LIM_NEG = -LIM_POS;
  localparam logic signed [YW-1:0] F_POS   = YW'(FMAX);
  localparam logic signed [YW-1:0] F_NEG   = -F_POS;
  localparam logic signed [YW-1:0] D_VAL   = YW'(DERIV_VAL);

  logic             en1, en2;
  logic [CH-1:0]    in_hi, in_lo;
  logic             s1_valid, s1_mode;
  logic [CH-1:0]    s1_hi, s1_lo;
  logic [CH*YW-1:0] s1_lin;
  logic             s2_valid;
  logic [CH*YW-1:0] y_nxt;

  // A stage advances when it is empty or the stage after it is moving.
  assign en2       = !s2_valid || out_ready;
  assign en1       = !s1_valid || en2;
  assign in_ready  = en1;
  assign out_valid = s2_valid;

  // Per-lane saturation compares on the raw input (boundary counts as saturated).
  always_comb begin
    in_hi = '0;
    in_lo = '0;
    for (int i = 0; i < CH; i++) begin
      in_hi[i] = $signed(in_x[i*XW +: XW]) >= LIM_POS;
      in_lo[i] = $signed(in_x[i*XW +: XW]) <= LIM_NEG;
    end
  end

  // S1 occupancy.
  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else if (en1) s1_valid <= in_valid;
  end

  // S1 payload: mode, compare flags and the pre-shifted linear value (only YW bits survive).
  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      s1_mode <= in_mode;
      s1_hi   <= in_hi;
      s1_lo   <= in_lo;
      for (int i = 0; i < CH; i++)
        s1_lin[i*YW +: YW] <= in_x[i*XW+SLOPE_SH +: YW];
    end
  end

  // Select saturated, linear or derivative result per lane.
  always_comb begin
    y_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      if (s1_hi[i])      y_nxt[i*YW +: YW] = s1_mode ? '0 : F_POS;
      else if (s1_lo[i]) y_nxt[i*YW +: YW] = s1_mode ? '0 : F_NEG;
      else               y_nxt[i*YW +: YW] = s1_mode ? D_VAL : s1_lin[i*YW +: YW];
    end
  end

  // S2 output register; holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      out_y    <= '0;
      out_mode <= 1'b0;
      sat_mask <= '0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_y    <= y_nxt;
        out_mode <= s1_mode;
        sat_mask <= s1_hi | s1_lo;
      end
    end
  end

`ifdef NN_ACT_SATCNT_EN
  logic [31:0] sat_pop;
  logic [32:0] cnt_sum;

  // Population count of the presented mask, added with carry-out for saturation.
  always_comb begin
    sat_pop = '0;
    for (int i = 0; i < CH; i++)
      sat_pop = sat_pop + 32'(sat_mask[i]);
    cnt_sum = {1'b0, sat_count} + {1'b0, sat_pop};
  end

  // Saturating event counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || sat_clr) sat_count <= '0;
    else if (out_valid && out_ready) sat_count <= cnt_sum[32] ? '1 : cnt_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_nn_act_unit.sv
// tb/tb_nn_act_unit.sv - scoreboard bench for nn_act_unit (counter test with NN_ACT_SATCNT_EN)
module tb_nn_act_unit;
  localparam int CH = 6, XW = 17, YW = 9, SH = 1, FMAX = 127, DV = 64;
  localparam int LIMIT = FMAX * (1 << SH);

  typedef struct packed {
    logic [CH*YW-1:0] y;
    logic             mode;
    logic [CH-1:0]    mask;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [CH*XW-1:0] in_x;
  logic [CH*YW-1:0] out_y;
  logic [CH-1:0]    sat_mask;
`ifdef NN_ACT_SATCNT_EN
  logic             sat_clr;
  logic [31:0]      sat_count;
`endif

  exp_t exp_q[$];
  int   out_cyc[$];
  int   n_cmp = 0, n_fail = 0, n_out = 0, cyc = 0, rdy_mode = 0;

  nn_act_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_mode(out_mode), .sat_mask(sat_mask)
`ifdef NN_ACT_SATCNT_EN
    , .sat_clr(sat_clr), .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: activation/derivative from the rule text with integer arithmetic.
  function automatic exp_t model(input logic [CH*XW-1:0] x, input logic mode);
    exp_t e;
    int xv, q, d;
    d = 1 << SH;
    e.y = '0; e.mode = mode; e.mask = '0;
    for (int i = 0; i < CH; i++) begin
      xv = int'($signed(x[i*XW +: XW]));
      if (xv >= LIMIT || xv <= -LIMIT) begin
        e.mask[i] = 1'b1;
        q = mode ? 0 : (xv > 0 ? FMAX : -FMAX);
      end else if (mode) begin
        q = DV;
      end else begin
        q = xv / d;
        if (xv % d != 0 && xv < 0) q = q - 1;
      end
      e.y[i*YW +: YW] = q[YW-1:0];
    end
    return e;
  endfunction

  function automatic logic [CH*XW-1:0] rand_x();
    logic [CH*XW-1:0] x;
    int v;
    for (int i = 0; i < CH; i++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 600)) - 300;
        1:       v = ($urandom_range(0, 1) ? 1 : -1) * int'($urandom_range(LIMIT - 1, LIMIT + 1));
        2:       v = int'($urandom_range(0, 131071)) - 65536;
        default: v = int'($urandom_range(0, 20)) - 10;
      endcase
      x[i*XW +: XW] = v[XW-1:0];
    end
    return x;
  endfunction

  function automatic logic [CH*XW-1:0] pack_x(input int a0, a1, a2, a3, a4, a5);
    logic [CH*XW-1:0] x;
    int a[CH];
    a = '{a0, a1, a2, a3, a4, a5};
    for (int i = 0; i < CH; i++) x[i*XW +: XW] = a[i][XW-1:0];
    return x;
  endfunction

  function automatic logic [CH*YW-1:0] pack_y(input int a0, a1, a2, a3, a4, a5);
    logic [CH*YW-1:0] y;
    int a[CH];
    a = '{a0, a1, a2, a3, a4, a5};
    for (int i = 0; i < CH; i++) y[i*YW +: YW] = a[i][YW-1:0];
    return y;
  endfunction

  // Offer one vector; push its expectation once the handshake is certain.
  task automatic send(input logic [CH*XW-1:0] x, input logic mode, input bit use_ex,
                      input exp_t ex, output int c);
    int waited;
    waited = 0;
    c = -1;
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_mode = mode;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      c = cyc;
      exp_q.push_back(use_ex ? ex : model(x, mode));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk); #2;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Downstream ready pattern.
  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pop/compare on output transfer; check hold while stalled.
  initial begin
    exp_t e;
    logic [CH*YW+CH:0] prev;
    bit prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({out_y, out_mode, sat_mask}), 64'(prev));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_y", 64'(out_y), 64'(e.y));
          check("out_mode", 64'(out_mode), 64'(e.mode));
          check("sat_mask", 64'(sat_mask), 64'(e.mask));
        end
        out_cyc.push_back(cyc);
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_y, out_mode, sat_mask};
    end
  end

  initial begin
    exp_t ex;
    logic [CH*XW-1:0] xd;
    int c, cprev, base, nsave, w;
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_x = '0; out_ready = 1'b1;
`ifdef NN_ACT_SATCNT_EN
    sat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_mode", 64'(out_mode), 64'd0);
    check("rst_sat_mask", 64'(sat_mask), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors with literal expectations and latency.
    xd = pack_x(0, 1, -3, 253, 254, -300);
    ex.y = pack_y(0, 0, -2, 126, 127, -127); ex.mode = 1'b0; ex.mask = 6'b110000;
    base = out_cyc.size();
    send(xd, 1'b0, 1'b1, ex, c);
    drain();
    check("latency_mode0", 64'(out_cyc[base] - c), 64'd2);
    ex.y = pack_y(64, 64, 64, 64, 0, 0); ex.mode = 1'b1; ex.mask = 6'b110000;
    base = out_cyc.size();
    send(xd, 1'b1, 1'b1, ex, c);
    drain();
    check("latency_mode1", 64'(out_cyc[base] - c), 64'd2);

    // Eight back-to-back vectors, alternating modes.
    base = out_cyc.size();
    cprev = 0;
    for (int k = 0; k < 8; k++) begin
      send(rand_x(), 1'(k % 2), 1'b0, ex, c);
      if (k > 0) check("b2b_in_gap", 64'(c - cprev), 64'd1);
      cprev = c;
    end
    drain();
    check("b2b_out_span", 64'(out_cyc[base+7] - out_cyc[base]), 64'd7);

    // Random vectors under random backpressure and input gaps.
    rdy_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(rand_x(), 1'($urandom_range(0, 1)), 1'b0, ex, c);
    end
    drain();

    // Reset with two vectors in flight.
    rdy_mode = 2;
    send(rand_x(), 1'b0, 1'b0, ex, c);
    send(rand_x(), 1'b1, 1'b0, ex, c);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    nsave = n_out;
    @(negedge clk); #1;
    check("rst_flight_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    rdy_mode = 0;
    repeat (6) @(negedge clk);
    #1;
    check("rst_no_stale", 64'(n_out - nsave), 64'd0);
    check("rst_idle_valid", 64'(out_valid), 64'd0);

`ifdef NN_ACT_SATCNT_EN
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
    send(xd, 1'b0, 1'b0, ex, c);
    send(pack_x(0, 0, 0, 0, 0, 0), 1'b1, 1'b0, ex, c);
    send(pack_x(300, -300, 254, -254, 9999, -9999), 1'b0, 1'b0, ex, c);
    drain();
    check("sat_count_sum", 64'(sat_count), 64'd8);
    send(pack_x(300, -300, 254, -254, 9999, -9999), 1'b1, 1'b0, ex, c);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    sat_clr = 1'b1;
    @(negedge clk); #1;
    sat_clr = 1'b0;
    check("sat_count_clr", 64'(sat_count), 64'd0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
